// File: rtl/mdu_iter_if.sv
// mdu_iter_if: start/busy/done request bus and HI/LO result bus of the iterative multiply/divide unit
// Ports (master = pipeline, slave = mdu_iter):
//   start, op[2:0], a, b, cancel : request side, driven by the master
//   busy, done, hi, lo           : status and HI/LO registers, driven by the slave
interface mdu_iter_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master(output start, op, a, b, cancel, input busy, done, hi, lo);
    modport slave(input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and MTHI/MTLO writes
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mdu_iter_if slave (start/op/a/b/cancel in, busy/done/hi/lo out)
module mdu_iter #(parameter int WIDTH = 32) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_iter_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               sa, sb, is_div, is_sgn;
    logic               busy, done;
    logic [WIDTH-1:0]   hi, lo;
    logic               accept, sgn_op;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     msum, dsh, ddif;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               neg;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.hi   = hi;
    assign bus.lo   = lo;
    always_comb begin
        accept   = bus.start & ~busy & ~done & ~bus.cancel;
        sgn_op   = ~bus.op[0];
        abs_a    = (sgn_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b    = (sgn_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;
        // acc = {partial product, remaining multiplier bits}
        msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : {WIDTH{1'b0}}};
        mul_next = {msum, acc[WIDTH-1:1]};
        // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
        dsh      = acc[2*WIDTH-1:WIDTH-1];
        ddif     = dsh - {1'b0, opnd};
        div_next = {ddif[WIDTH] ? dsh[WIDTH-1:0] : ddif[WIDTH-1:0], acc[WIDTH-2:0], ~ddif[WIDTH]};
        neg      = is_sgn & (sa ^ sb);
        prod     = neg ? -acc : acc;
        quo      = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = (is_sgn & sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            is_div <= 1'b0;
            is_sgn <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (!bus.op[2]) begin
                        if (bus.op[1] && bus.b == '0) begin
                            lo   <= '1;
                            hi   <= bus.a;
                            done <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy   <= 1'b1;
                            cnt    <= '0;
                            acc    <= {{WIDTH{1'b0}}, bus.op[1] ? abs_a : abs_b};
                            opnd   <= bus.op[1] ? abs_b : abs_a;
                            sa     <= sgn_op & bus.a[WIDTH-1];
                            sb     <= sgn_op & bus.b[WIDTH-1];
                            is_div <= bus.op[1];
                            is_sgn <= sgn_op;
                        end
                    end else if (!bus.op[1]) begin
                        if (bus.op[0]) lo <= bus.a;
                        else hi <= bus.a;
                        done <= 1'b1;
                    end
                end
                CALC: if (bus.cancel) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!bus.cancel) begin
                        hi   <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
                        lo   <= is_div ? quo : prod[WIDTH-1:0];
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter at WIDTH=32 and WIDTH=8 against an arithmetic reference model
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    mdu_iter_if #(.WIDTH(32)) i32 ();
    mdu_iter_if #(.WIDTH(8))  i8 ();
    mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));
    mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    int total = 0;
    int bad = 0;
    logic [31:0] mh [2];
    logic [31:0] ml [2];
    typedef struct {
        bit          s8;
        logic [2:0]  op;
        logic [31:0] a, b, eh, el;
    } vec_t;
    vec_t tv [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic dn(input bit s8);
        return s8 ? i8.done : i32.done;
    endfunction
    function automatic logic bsy(input bit s8);
        return s8 ? i8.busy : i32.busy;
    endfunction
    function automatic logic [31:0] rhi(input bit s8);
        return s8 ? {24'b0, i8.hi} : i32.hi;
    endfunction
    function automatic logic [31:0] rlo(input bit s8);
        return s8 ? {24'b0, i8.lo} : i32.lo;
    endfunction

    // returns {hi, lo} from plain signed/unsigned arithmetic on w-bit operands
    function automatic logic [63:0] ref_res(input int w, input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] ph, input logic [31:0] pl);
        logic [63:0] mask, pu;
        longint av, bv, p, q, r;
        bit sg;
        mask = (w == 32) ? 64'hFFFF_FFFF : (64'd1 << w) - 64'd1;
        sg = (op == 3'd0) || (op == 3'd2);
        av = longint'(a);
        bv = longint'(b);
        if (sg && a[w-1]) av -= (longint'(1) << w);
        if (sg && b[w-1]) bv -= (longint'(1) << w);
        case (op)
            3'd0, 3'd1: begin
                p = av * bv;
                pu = p;
                return {32'((pu >> w) & mask), 32'(pu & mask)};
            end
            3'd2, 3'd3: begin
                if (bv == 0) return {a, 32'(mask)};
                q = av / bv;
                r = av % bv;
                return {32'(r & mask), 32'(q & mask)};
            end
            3'd4: return {a, pl};
            3'd5: return {ph, a};
            default: return {ph, pl};
        endcase
    endfunction

    task automatic drive(input bit s8, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        if (s8) begin
            i8.start = 1'b1; i8.op = o; i8.a = av[7:0]; i8.b = bv[7:0];
        end else begin
            i32.start = 1'b1; i32.op = o; i32.a = av; i32.b = bv;
        end
        @(posedge clk);
        #1;
        i8.start = 1'b0;
        i32.start = 1'b0;
    endtask

    task automatic count_done(input bit s8, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (dn(s8)) n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run(input bit s8, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        int w = s8 ? 8 : 32;
        logic [63:0] exp;
        bit fast, bad_busy;
        int n;
        exp = ref_res(w, o, av, bv, mh[s8], ml[s8]);
        fast = o[2] || (o[1] && bv == 32'd0);
        drive(s8, o, av, bv);
        n = 0;
        bad_busy = 1'b0;
        while (!dn(s8) && n < 100) begin
            if (bsy(s8) !== 1'b1) bad_busy = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, fast ? 0 : w + 1);
        chk("busy_during_op", {31'b0, bad_busy}, 0);
        chk("busy_at_done", {31'b0, bsy(s8)}, 0);
        chk("hi", rhi(s8), exp[63:32]);
        chk("lo", rlo(s8), exp[31:0]);
        mh[s8] = exp[63:32];
        ml[s8] = exp[31:0];
        @(posedge clk);
        #1;
        chk("done_one_pulse", {31'b0, dn(s8)}, 0);
    endtask

    initial begin
        int n;
        i32.start = 0; i32.op = 0; i32.a = 0; i32.b = 0; i32.cancel = 0;
        i8.start = 0;  i8.op = 0;  i8.a = 0;  i8.b = 0;  i8.cancel = 0;
        mh = '{0, 0};
        ml = '{0, 0};
        tv[0] = '{0, 3'd0, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE};
        tv[1] = '{0, 3'd1, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE};
        tv[2] = '{0, 3'd2, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tv[3] = '{0, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        tv[4] = '{0, 3'd3, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF};
        tv[5] = '{0, 3'd3, 32'd100, 32'd7, 32'd2, 32'd14};
        tv[6] = '{1, 3'd0, 32'h80, 32'h80, 32'h40, 32'h00};
        tv[7] = '{1, 3'd2, 32'h80, 32'hFF, 32'h00, 32'h80};
        tv[8] = '{1, 3'd3, 32'd200, 32'd7, 32'd4, 32'd28};
        tv[9] = '{1, 3'd1, 32'hFF, 32'hFF, 32'hFE, 32'h01};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_hi", i32.hi, 0);
        chk("reset_lo", i32.lo, 0);
        chk("reset_busy", {31'b0, i32.busy}, 0);
        chk("reset_done", {31'b0, i32.done}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            run(tv[i].s8, tv[i].op, tv[i].a, tv[i].b);
            chk("tv_hi", rhi(tv[i].s8), tv[i].eh);
            chk("tv_lo", rlo(tv[i].s8), tv[i].el);
        end

        run(0, 3'd4, 32'hAAAA0000, 32'h0);
        drive(0, 3'd3, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        i32.cancel = 1'b1;
        @(posedge clk);
        #1;
        i32.cancel = 1'b0;
        chk("cancel_busy", {31'b0, i32.busy}, 0);
        chk("cancel_done", {31'b0, i32.done}, 0);
        count_done(0, 40, n);
        chk("cancel_no_done", n, 0);
        chk("cancel_hi", i32.hi, 32'hAAAA0000);
        run(0, 3'd3, 32'd100, 32'd7);
        chk("after_cancel_lo", i32.lo, 32'd14);
        chk("after_cancel_hi", i32.hi, 32'd2);

        drive(0, 3'd1, 32'd5, 32'd5);
        repeat (3) @(posedge clk);
        drive(0, 3'd0, 32'd3, 32'd3);
        count_done(0, 45, n);
        chk("busy_start_single_done", n, 1);
        chk("busy_start_lo", i32.lo, 32'd25);
        chk("busy_start_hi", i32.hi, 32'd0);
        mh[0] = 0;
        ml[0] = 25;
        run(0, 3'd5, 32'h55, 32'h0);
        chk("mtlo_lo", i32.lo, 32'h55);

        drive(0, 3'd6, 32'h1234, 32'h5);
        count_done(0, 4, n);
        chk("op6_no_done", n, 0);
        chk("op6_hi", i32.hi, mh[0]);
        chk("op6_lo", i32.lo, ml[0]);

        for (int i = 0; i < 80; i++) begin
            bit s8;
            logic [2:0] o;
            logic [31:0] av, bv;
            s8 = 1'($urandom_range(0, 1));
            o = 3'($urandom_range(0, 5));
            av = ($urandom_range(0, 7) == 0) ? (s8 ? 32'h80 : 32'h80000000) : $urandom;
            bv = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 15)));
            if (s8) begin
                av &= 32'hFF;
                bv &= 32'hFF;
            end
            run(s8, o, av, bv);
        end

        drive(0, 3'd0, 32'd7, 32'd9);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_hi", i32.hi, 0);
        chk("rst_lo", i32.lo, 0);
        chk("rst_busy", {31'b0, i32.busy}, 0);
        chk("rst_done", {31'b0, i32.done}, 0);
        chk("rst_hi8", {24'b0, i8.hi}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(0, 40, n);
        chk("rst_no_done", n, 0);
        mh = '{0, 0};
        ml = '{0, 0};
        run(1, 3'd0, 32'h80, 32'h80);
        run(0, 3'd2, 32'hFFFFFFF9, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
